// File: rtl/mem_pkg.sv
// Shared width constants and word type for the 1R1W core memory.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mem_1r1w.sv
// 1024 x 32 single-clock memory with one write port and one registered read port.
// Read-during-write to one address is read-first; define MEM_BYPASS_EN for write-first forwarding.
module mem_1r1w #(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [ADDR_W-1:0] addr_r,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_next;

    // Array has no reset; the reset branch only blocks writes while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            mem[addr_w] <= data_in;
        end
    end

`ifdef MEM_BYPASS_EN
    assign rd_next = (addr_r == addr_w) ? data_in : mem[addr_r];
`else
    assign rd_next = mem[addr_r];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= rd_next;
        end
    end

endmodule

// File: tb/tb_mem_1r1w.sv
// Directed-vector bench for mem_1r1w: table of per-edge write/read records plus reset sequences.
module tb_mem_1r1w;
    import mem_pkg::*;

    localparam logic [ADDR_W-1:0] SCR = 10'd512;
`ifdef MEM_BYPASS_EN
    localparam word_t COLL = 32'h2222_2222;
`else
    localparam word_t COLL = 32'h1111_1111;
`endif

    typedef struct {
        logic [ADDR_W-1:0] aw;
        word_t             d;
        logic [ADDR_W-1:0] ar;
        bit                chk;
        word_t             exp;
    } vec_t;

    logic              clk;
    logic              rst_n;
    word_t             data_in;
    logic [ADDR_W-1:0] addr_w;
    logic [ADDR_W-1:0] addr_r;
    word_t             data_out;

    int n_vec;
    int n_bad;
    vec_t vt[19];

    mem_1r1w dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .addr_w   (addr_w),
        .addr_r   (addr_r),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [ADDR_W-1:0] aw, input word_t d,
                                input logic [ADDR_W-1:0] ar, input bit chk, input word_t exp);
        vec_t v;
        v.aw = aw; v.d = d; v.ar = ar; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input word_t exp);
        n_vec++;
        if (data_out !== exp) begin
            n_bad++;
            $display("FAIL %s: data_out=%h expected %h", name, data_out, exp);
        end
    endtask

    // Drive at negedge, sample 1 time unit after the following posedge.
    task automatic step(input logic [ADDR_W-1:0] aw, input word_t d, input logic [ADDR_W-1:0] ar);
        @(negedge clk);
        addr_w  = aw;
        data_in = d;
        addr_r  = ar;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        vt[0]  = mk(10'd0,    32'hAAAA_BBBB, SCR,      0, '0);
        vt[1]  = mk(10'd1,    32'h1234_5678, SCR,      0, '0);
        vt[2]  = mk(10'd2,    32'hDEAD_BEEF, 10'd0,    1, 32'hAAAA_BBBB);
        vt[3]  = mk(SCR,      '0,            10'd1,    1, 32'h1234_5678);
        vt[4]  = mk(SCR,      '0,            10'd2,    1, 32'hDEAD_BEEF);
        vt[5]  = mk(10'd1,    32'hFFFF_0000, SCR,      1, '0);
        vt[6]  = mk(SCR,      '0,            10'd1,    1, 32'hFFFF_0000);
        vt[7]  = mk(10'd5,    32'h1111_1111, SCR,      1, '0);
        vt[8]  = mk(10'd5,    32'h2222_2222, 10'd5,    1, COLL);
        vt[9]  = mk(SCR,      '0,            10'd5,    1, 32'h2222_2222);
        vt[10] = mk(10'd0,    32'h0000_0001, SCR,      1, '0);
        vt[11] = mk(10'd1023, 32'h8000_0000, 10'd0,    1, 32'h0000_0001);
        vt[12] = mk(SCR,      '0,            10'd1023, 1, 32'h8000_0000);
        vt[13] = mk(SCR,      '0,            10'd0,    1, 32'h0000_0001);
        vt[14] = mk(10'd1022, 32'h0000_0007, 10'd1,    1, 32'hFFFF_0000);
        vt[15] = mk(10'd2,    32'h0BAD_F00D, 10'd1022, 1, 32'h0000_0007);
        vt[16] = mk(SCR,      '0,            10'd2,    1, 32'h0BAD_F00D);
        vt[17] = mk(10'd7,    32'h1357_9BDF, SCR,      1, '0);
        vt[18] = mk(SCR,      '0,            10'd7,    1, 32'h1357_9BDF);

        rst_n   = 1'b0;
        addr_w  = SCR;
        addr_r  = SCR;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(vt[i].aw, vt[i].d, vt[i].ar);
            if (vt[i].chk) check($sformatf("vec%0d", i), vt[i].exp);
        end

        // Asynchronous clear: data_out is nonzero here and must drop with no clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", '0);

        // Writes attempted under reset must not reach the array.
        addr_w  = 10'd7;
        data_in = 32'hCAFE_F00D;
        addr_r  = 10'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", i), '0);
        end

        // First edge after release does a normal write and a normal read.
        @(negedge clk);
        addr_w  = 10'd3;
        data_in = 32'h3333_4444;
        addr_r  = 10'd7;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_rd7", 32'h1357_9BDF);
        step(SCR, '0, 10'd3);
        check("post_reset_wr3", 32'h3333_4444);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
